ddr5_phy_write_seq: RTL and testbench
=====================================

// Module: ddr5_phy_write_seq
// PURPOSE
//  Next-gen DDR5 PHY write sequencer: multi-lane, self-timed (internal preamble/burst/postamble counters, no *_done inputs).
//  Sits between freq-ratio block and DRAM pads; drives DQ/DQS/DM per lane, feeds CRC block, queues back-to-back writes.
//  Supports BL16, BC8 (all-ones fill), optional PHY CRC beat, seamless bursts and programmable pre/postamble length.
// PARAMETERS
//  pDRAM_SIZE  4  device width x4/x8/x16; DQ per lane per clk = 2*pDRAM_SIZE (2 beats)
//  pNUM_LANES  1  number of devices/lanes driven in lockstep
//  pMAX_PEND   2  max queued write commands (saturating counter)
// PORTS
//  clk_i            in   1                          PHY clock
//  rst_i            in   1                          async active-low reset
//  enable_i         in   1                          0: state, counters, registered outputs hold
//  wr_en_i          in   1                          1-cycle pulse = one write command
//  crc_generate_i   in   1                          1: PHY appends CRC beat; latched at burst start
//  burstlength_i    in   2                          00 BL16, 01 BC8, others = BL16; latched at burst start
//  preamble_len_i   in   2                          preamble cycles = value+1 (1..4); latched on PRE entry
//  postamble_len_i  in   1                          0: 1 cycle, 1: 2 cycles; latched on POST entry
//  wr_data_i        in   pNUM_LANES*2*pDRAM_SIZE    write data, valid when data_req_o=1
//  wr_datamask_i    in   pNUM_LANES*pDRAM_SIZE/4    data mask, valid when data_req_o=1
//  crc_code_i       in   pNUM_LANES*2*pDRAM_SIZE    CRC from CRC block, valid in CRC state
//  data_req_o       out  1                          comb: state==DATA, upstream must present data
//  crc_enable_o     out  1                          comb: crc_cfg & state in {DATA,FILL,CRC}
//  crc_data_o       out  pNUM_LANES*2*pDRAM_SIZE    comb: DATA->wr_data_i, FILL->all 1s, else 0
//  dq_o / dm_o      out  as inputs                  registered DQ / DM
//  dqs_o            out  pNUM_LANES*2               registered strobe, identical per lane
//  dq_valid_o       out  1                          registered DQ drive enable
//  dqs_valid_o      out  1                          registered DQS drive enable
//  state_o          out  3                          current state (debug)
//  err_o            out  1                          sticky: command dropped on queue overflow
// BEHAVIOUR
//  Reset: state IDLE, pend=0, all counters 0, every output 0 (comb outputs follow IDLE).
//  Outputs dq/dm/dqs/valids: computed from current state, registered -> 1-cycle latency after state.
//  IDLE: dqs=00, valids 0. wr_en_i=1 -> PRE (load pre_cnt=preamble_len_i).
//  PRE: dqs=00 except last cycle dqs=10; dqs_valid=1, dq_valid=0. pre_cnt==0 -> DATA.
//  DATA: dq=wr_data_i, dm=wr_datamask_i, dqs=10, both valids 1. Cycles: BL16 8, BC8 4.
//    last cycle: BC8 -> FILL; else crc_cfg -> CRC; else END.
//  FILL: 4 cycles, dq=all 1s, dm=0, dqs=10, valids 1; then crc_cfg -> CRC else END.
//  CRC: 1 cycle, dq=crc_code_i, dm=0, dqs=10, valids 1; then END.
//  END (decision, not a state): pend>0 or wr_en_i this cycle -> DATA seamless (no preamble, relatch cfg,
//    consume one); else POST (load post_cnt).
//  POST: dqs=00, dqs_valid=1, dq_valid=0. post_cnt==0: pend>0 -> PRE (consume one), else IDLE.
//  Queue: wr_en_i while state!=IDLE and not consumed same cycle -> pend+1; consume -> pend-1;
//    simultaneous arrive+consume -> pend unchanged. At pend==pMAX_PEND further wr_en_i dropped, err_o=1.
//  Example: wr_en_i at T0 (IDLE), preamble_len_i=1 -> PRE T1..T2, DATA T3..T10, dqs_valid_o 1 from T2.
//  enable_i=0 mid-burst: everything frozen incl. beat counters; resumes exactly where stopped.
//  rst_i low mid-burst: immediate IDLE, outputs 0, pend and err_o cleared.
//  Config inputs changing mid-burst: no effect until next latch point.
// STRUCTURE
//  Package ddr5_phy_write_pkg: wr_state_t {IDLE,PRE,DATA,FILL,CRC,POST}, BL16_CYC=8, BC8_CYC=4,
//    FILL_CYC=4, burst-length encodings.
//  Sub-module ddr5_phy_wr_cmd_q: saturating pending-command counter (inc/dec/full/err); rest in top.
// TESTING
//  Single BL16, crc=0, pre_len=1, post_len=0: dqs_valid_o 2+8+1 cycles, dq_o = 8 data words, then IDLE.
//  BC8 crc=1: 4 data + 4 x all-1s + 1 CRC on dq_o; crc_enable_o high 9 cycles; crc_data_o 1s in FILL.
//  Second wr_en_i during DATA: no POST/PRE, DATA resumes directly after CRC/data end, pend returns 0.
//  wr_en_i during POST (post_len=1): POST 2 cycles then PRE with dqs_o=00..10 again, then DATA.
//  pMAX_PEND=2: 4 pulses during one burst -> 2 queued, 1 dropped, err_o=1 until rst_i.
//  enable_i low 3 cycles in DATA and rst_i pulse mid-PRE: outputs hold / clear to 0, state IDLE.

Source files
------------

// File: rtl/ddr5_phy_write_pkg.sv
// Shared types and constants for the DDR5 PHY write sequencer.
package ddr5_phy_write_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    DATA = 3'd2,
    FILL = 3'd3,
    CRC  = 3'd4,
    POST = 3'd5
  } wr_state_t;

  localparam int BL16_CYC = 8;
  localparam int BC8_CYC  = 4;
  localparam int FILL_CYC = 4;

  localparam logic [1:0] BL_BL16 = 2'b00;
  localparam logic [1:0] BL_BC8  = 2'b01;

  // Index of the final DATA beat for the latched burst type.
  function automatic logic [2:0] last_beat(input logic bc8);
    if (bc8) begin
      return 3'(BC8_CYC - 1);
    end else begin
      return 3'(BL16_CYC - 1);
    end
  endfunction

endpackage

// File: rtl/ddr5_phy_wr_cmd_q.sv
// Saturating count of write commands waiting behind the active burst.
// An arrival that finds the queue full is dropped and raises a sticky error.
module ddr5_phy_wr_cmd_q import ddr5_phy_write_pkg::*; #(
  parameter int pMAX_PEND = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic pend_nz_o,
  output logic err_o
);

  localparam int CNT_W = $clog2(pMAX_PEND + 1);

  logic [CNT_W-1:0] pend_r;
  logic             err_r;
  logic             full_s;

  assign full_s    = (pend_r == CNT_W'(pMAX_PEND));
  assign pend_nz_o = (pend_r != {CNT_W{1'b0}});
  assign err_o     = err_r;

  // Pending-count update; simultaneous arrive and consume leaves it unchanged.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend_r <= {CNT_W{1'b0}};
      err_r  <= 1'b0;
    end else if (enable_i) begin
      if (inc_i && !dec_i) begin
        if (full_s) begin
          err_r <= 1'b1;
        end else begin
          pend_r <= pend_r + CNT_W'(1);
        end
      end else if (dec_i && !inc_i && (pend_r != {CNT_W{1'b0}})) begin
        pend_r <= pend_r - CNT_W'(1);
      end else begin
        pend_r <= pend_r;
      end
    end else begin
      pend_r <= pend_r;
    end
  end

endmodule

// File: rtl/ddr5_phy_write_seq.sv
// DDR5 PHY write sequencer: self-timed preamble / data / fill / CRC /
// postamble sequencing per burst with seamless back-to-back writes.
// Pad-side outputs are registered one cycle behind the state.
module ddr5_phy_write_seq import ddr5_phy_write_pkg::*; #(
  parameter int pDRAM_SIZE = 4,
  parameter int pNUM_LANES = 1,
  parameter int pMAX_PEND  = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               enable_i,
  input  logic                               wr_en_i,
  input  logic                               crc_generate_i,
  input  logic [1:0]                         burstlength_i,
  input  logic [1:0]                         preamble_len_i,
  input  logic                               postamble_len_i,
  input  logic [pNUM_LANES*2*pDRAM_SIZE-1:0] wr_data_i,
  input  logic [pNUM_LANES*pDRAM_SIZE/4-1:0] wr_datamask_i,
  input  logic [pNUM_LANES*2*pDRAM_SIZE-1:0] crc_code_i,
  output logic                               data_req_o,
  output logic                               crc_enable_o,
  output logic [pNUM_LANES*2*pDRAM_SIZE-1:0] crc_data_o,
  output logic [pNUM_LANES*2*pDRAM_SIZE-1:0] dq_o,
  output logic [pNUM_LANES*pDRAM_SIZE/4-1:0] dm_o,
  output logic [pNUM_LANES*2-1:0]            dqs_o,
  output logic                               dq_valid_o,
  output logic                               dqs_valid_o,
  output logic [2:0]                         state_o,
  output logic                               err_o
);

  localparam int DW = pNUM_LANES * 2 * pDRAM_SIZE;
  localparam int MW = pNUM_LANES * pDRAM_SIZE / 4;
  localparam logic [pNUM_LANES*2-1:0] DQS_HI = {pNUM_LANES{2'b10}};
  localparam logic [pNUM_LANES*2-1:0] DQS_LO = {pNUM_LANES{2'b00}};

  wr_state_t state_r, state_s;
  logic [1:0] pre_cnt_r, pre_cnt_s;
  logic       post_cnt_r, post_cnt_s;
  logic [2:0] beat_cnt_r, beat_cnt_s;
  logic       bc8_r, bc8_s;
  logic       crc_cfg_r, crc_cfg_s;
  logic       consume_s, burst_end_s, seamless_s, pend_nz_s, queue_inc_s;

  logic [DW-1:0]           dq_s;
  logic [MW-1:0]           dm_s;
  logic [pNUM_LANES*2-1:0] dqs_s;
  logic                    dq_valid_s, dqs_valid_s;

  // A new burst may follow immediately if one is queued or arriving now.
  assign seamless_s  = pend_nz_s | wr_en_i;
  assign queue_inc_s = enable_i & wr_en_i & (state_r != IDLE);

  ddr5_phy_wr_cmd_q #(.pMAX_PEND(pMAX_PEND)) u_cmd_q (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .enable_i  (enable_i),
    .inc_i     (queue_inc_s),
    .dec_i     (enable_i & consume_s),
    .pend_nz_o (pend_nz_s),
    .err_o     (err_o)
  );

  // Next-state, counter and configuration-latch decisions.
  always_comb begin
    state_s     = state_r;
    pre_cnt_s   = pre_cnt_r;
    post_cnt_s  = post_cnt_r;
    beat_cnt_s  = beat_cnt_r;
    bc8_s       = bc8_r;
    crc_cfg_s   = crc_cfg_r;
    consume_s   = 1'b0;
    burst_end_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (wr_en_i) begin
          state_s   = PRE;
          pre_cnt_s = preamble_len_i;
        end else begin
          state_s = IDLE;
        end
      end
      PRE: begin
        if (pre_cnt_r == 2'd0) begin
          state_s    = DATA;
          beat_cnt_s = 3'd0;
          bc8_s      = (burstlength_i == BL_BC8);
          crc_cfg_s  = crc_generate_i;
        end else begin
          pre_cnt_s = pre_cnt_r - 2'd1;
        end
      end
      DATA: begin
        if (beat_cnt_r == last_beat(bc8_r)) begin
          if (bc8_r) begin
            state_s    = FILL;
            beat_cnt_s = 3'd0;
          end else if (crc_cfg_r) begin
            state_s = CRC;
          end else begin
            burst_end_s = 1'b1;
          end
        end else begin
          beat_cnt_s = beat_cnt_r + 3'd1;
        end
      end
      FILL: begin
        if (beat_cnt_r == 3'(FILL_CYC - 1)) begin
          if (crc_cfg_r) begin
            state_s = CRC;
          end else begin
            burst_end_s = 1'b1;
          end
        end else begin
          beat_cnt_s = beat_cnt_r + 3'd1;
        end
      end
      CRC: begin
        burst_end_s = 1'b1;
      end
      POST: begin
        if (post_cnt_r == 1'b0) begin
          if (seamless_s) begin
            state_s   = PRE;
            pre_cnt_s = preamble_len_i;
            consume_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          post_cnt_s = post_cnt_r - 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if (burst_end_s) begin
      if (seamless_s) begin
        state_s    = DATA;
        consume_s  = 1'b1;
        beat_cnt_s = 3'd0;
        bc8_s      = (burstlength_i == BL_BC8);
        crc_cfg_s  = crc_generate_i;
      end else begin
        state_s    = POST;
        post_cnt_s = postamble_len_i;
      end
    end else begin
      // Mid-burst: the case above already chose the next state.
    end
  end

  // Sequencer state and counters; everything freezes while enable_i is low.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r    <= IDLE;
      pre_cnt_r  <= 2'd0;
      post_cnt_r <= 1'b0;
      beat_cnt_r <= 3'd0;
      bc8_r      <= 1'b0;
      crc_cfg_r  <= 1'b0;
    end else if (enable_i) begin
      state_r    <= state_s;
      pre_cnt_r  <= pre_cnt_s;
      post_cnt_r <= post_cnt_s;
      beat_cnt_r <= beat_cnt_s;
      bc8_r      <= bc8_s;
      crc_cfg_r  <= crc_cfg_s;
    end else begin
      state_r <= state_r;
    end
  end

  // Pad values implied by the current state, captured on the next edge.
  always_comb begin
    dq_s        = {DW{1'b0}};
    dm_s        = {MW{1'b0}};
    dqs_s       = DQS_LO;
    dq_valid_s  = 1'b0;
    dqs_valid_s = 1'b0;
    case (state_r)
      IDLE: begin
        dqs_s = DQS_LO;
      end
      PRE: begin
        dqs_valid_s = 1'b1;
        if (pre_cnt_r == 2'd0) begin
          dqs_s = DQS_HI;
        end else begin
          dqs_s = DQS_LO;
        end
      end
      DATA: begin
        dq_s        = wr_data_i;
        dm_s        = wr_datamask_i;
        dqs_s       = DQS_HI;
        dq_valid_s  = 1'b1;
        dqs_valid_s = 1'b1;
      end
      FILL: begin
        dq_s        = {DW{1'b1}};
        dqs_s       = DQS_HI;
        dq_valid_s  = 1'b1;
        dqs_valid_s = 1'b1;
      end
      CRC: begin
        dq_s        = crc_code_i;
        dqs_s       = DQS_HI;
        dq_valid_s  = 1'b1;
        dqs_valid_s = 1'b1;
      end
      POST: begin
        dqs_valid_s = 1'b1;
      end
      default: begin
        dqs_s = DQS_LO;
      end
    endcase
  end

  // Registered pad outputs, held while disabled.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dq_o        <= {DW{1'b0}};
      dm_o        <= {MW{1'b0}};
      dqs_o       <= DQS_LO;
      dq_valid_o  <= 1'b0;
      dqs_valid_o <= 1'b0;
    end else if (enable_i) begin
      dq_o        <= dq_s;
      dm_o        <= dm_s;
      dqs_o       <= dqs_s;
      dq_valid_o  <= dq_valid_s;
      dqs_valid_o <= dqs_valid_s;
    end else begin
      dq_o <= dq_o;
    end
  end

  // Upstream data request and CRC-block feed follow the live state.
  always_comb begin
    crc_data_o = {DW{1'b0}};
    case (state_r)
      DATA:    crc_data_o = wr_data_i;
      FILL:    crc_data_o = {DW{1'b1}};
      default: crc_data_o = {DW{1'b0}};
    endcase
  end

  assign data_req_o   = (state_r == DATA);
  assign crc_enable_o = crc_cfg_r & ((state_r == DATA) | (state_r == FILL) | (state_r == CRC));
  assign state_o      = state_r;

endmodule

// File: tb/tb_ddr5_phy_write_seq.sv
// Directed bench for ddr5_phy_write_seq (x4, one lane, two pending slots).
// Each scenario is a table of per-cycle controls; outputs are recorded per
// cycle (inputs driven on the falling edge) and compared with hand-derived values.
module tb_ddr5_phy_write_seq;

  localparam logic [2:0] S_IDLE = 3'd0, S_PRE = 3'd1, S_DATA = 3'd2;
  localparam logic [2:0] S_FILL = 3'd3, S_CRC = 3'd4, S_POST = 3'd5;

  logic       clk_i = 1'b0;
  logic       rst_i, enable_i, wr_en_i, crc_generate_i, postamble_len_i;
  logic [1:0] burstlength_i, preamble_len_i;
  logic [7:0] wr_data_i, crc_code_i, crc_data_o, dq_o;
  logic [0:0] wr_datamask_i, dm_o;
  logic       data_req_o, crc_enable_o, dq_valid_o, dqs_valid_o, err_o;
  logic [1:0] dqs_o;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_pass   = 0;
  int cnt;

  logic       wen_t [64];
  logic       en_t  [64];
  logic       rst_t [64];
  logic [2:0] st_r  [64];
  logic [1:0] dqs_r [64];
  logic [7:0] dq_r  [64];
  logic [7:0] cd_r  [64];
  logic       dv_r  [64];
  logic       qv_r  [64];
  logic       ce_r  [64];
  logic       er_r  [64];
  logic       rq_r  [64];
  logic       dm_r  [64];

  ddr5_phy_write_seq #(.pDRAM_SIZE(4), .pNUM_LANES(1), .pMAX_PEND(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .wr_en_i(wr_en_i),
    .crc_generate_i(crc_generate_i), .burstlength_i(burstlength_i),
    .preamble_len_i(preamble_len_i), .postamble_len_i(postamble_len_i),
    .wr_data_i(wr_data_i), .wr_datamask_i(wr_datamask_i), .crc_code_i(crc_code_i),
    .data_req_o(data_req_o), .crc_enable_o(crc_enable_o), .crc_data_o(crc_data_o),
    .dq_o(dq_o), .dm_o(dm_o), .dqs_o(dqs_o), .dq_valid_o(dq_valid_o),
    .dqs_valid_o(dqs_valid_o), .state_o(state_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < 64; i++) begin
      wen_t[i] = 1'b0;
      en_t[i]  = 1'b1;
      rst_t[i] = 1'b0;
    end
  endtask

  // Cycle k: drive on the falling edge, sample 1 ns later. Data word = 0x40+k.
  task automatic run(input int n);
    for (int k = 0; k <= n; k++) begin
      @(negedge clk_i);
      wr_en_i       = wen_t[k];
      enable_i      = en_t[k];
      rst_i         = ~rst_t[k];
      wr_data_i     = 8'(8'h40 + k);
      wr_datamask_i = 1'(k & 1);
      #1;
      st_r[k] = state_o;   dqs_r[k] = dqs_o;      dq_r[k] = dq_o;
      cd_r[k] = crc_data_o; dv_r[k] = dqs_valid_o; qv_r[k] = dq_valid_o;
      ce_r[k] = crc_enable_o; er_r[k] = err_o;    rq_r[k] = data_req_o;
      dm_r[k] = dm_o[0];
    end
  endtask

  task automatic set_cfg(input logic crc, input logic [1:0] bl,
                         input logic [1:0] pre, input logic post);
    crc_generate_i  = crc;
    burstlength_i   = bl;
    preamble_len_i  = pre;
    postamble_len_i = post;
  endtask

  initial begin
    rst_i = 1'b0; enable_i = 1'b1; wr_en_i = 1'b0; crc_code_i = 8'hC5;
    wr_data_i = 8'h5A; wr_datamask_i = 1'b1;
    set_cfg(1'b0, 2'b00, 2'd1, 1'b0);
    @(negedge clk_i); @(negedge clk_i); #1;
    check("rst_state", state_o, S_IDLE);
    check("rst_dq_valid", dq_valid_o, 1'b0);
    check("rst_dqs_valid", dqs_valid_o, 1'b0);
    check("rst_dqs", dqs_o, 2'b00);
    check("rst_dq", dq_o, 8'h00);
    check("rst_err", err_o, 1'b0);
    check("rst_req", data_req_o, 1'b0);
    check("rst_crc_data", crc_data_o, 8'h00);
    rst_i = 1'b1;

    // Single BL16, no CRC, preamble 2 cycles, postamble 1 cycle.
    clear_tbl(); wen_t[0] = 1'b1;
    run(13);
    check("t1_st1_pre", st_r[1], S_PRE);
    check("t1_st2_pre", st_r[2], S_PRE);
    check("t1_st3_data", st_r[3], S_DATA);
    check("t1_st10_data", st_r[10], S_DATA);
    check("t1_st11_post", st_r[11], S_POST);
    check("t1_st12_idle", st_r[12], S_IDLE);
    cnt = 0; for (int k = 0; k <= 13; k++) cnt += int'(dv_r[k]);
    check("t1_dqs_valid_cycles", cnt, 11);
    cnt = 0; for (int k = 0; k <= 13; k++) cnt += int'(qv_r[k]);
    check("t1_dq_valid_cycles", cnt, 8);
    check("t1_dq_first", dq_r[4], 8'h43);
    check("t1_dq_last", dq_r[11], 8'h4A);
    check("t1_dm_odd", dm_r[4], 1'b1);
    check("t1_dm_even", dm_r[5], 1'b0);
    check("t1_dqs_pre_lo", dqs_r[2], 2'b00);
    check("t1_dqs_pre_last", dqs_r[3], 2'b10);
    check("t1_dqs_post", dqs_r[12], 2'b00);
    check("t1_dv_post", dv_r[12], 1'b1);
    check("t1_dv_idle", dv_r[13], 1'b0);
    check("t1_req_pre", rq_r[2], 1'b0);
    check("t1_req_data", rq_r[3], 1'b1);
    check("t1_crc_en_off", ce_r[3], 1'b0);

    // BC8 with CRC, preamble 1 cycle.
    set_cfg(1'b1, 2'b01, 2'd0, 1'b0);
    clear_tbl(); wen_t[0] = 1'b1;
    run(13);
    check("t2_st2_data", st_r[2], S_DATA);
    check("t2_st6_fill", st_r[6], S_FILL);
    check("t2_st10_crc", st_r[10], S_CRC);
    check("t2_st11_post", st_r[11], S_POST);
    check("t2_st12_idle", st_r[12], S_IDLE);
    cnt = 0; for (int k = 0; k <= 13; k++) cnt += int'(ce_r[k]);
    check("t2_crc_en_cycles", cnt, 9);
    cnt = 0; for (int k = 0; k <= 13; k++) cnt += int'(qv_r[k]);
    check("t2_dq_valid_cycles", cnt, 9);
    check("t2_crc_data_data", cd_r[3], 8'h43);
    check("t2_crc_data_fill", cd_r[7], 8'hFF);
    check("t2_crc_data_post", cd_r[11], 8'h00);
    check("t2_dqs_pre_last", dqs_r[2], 2'b10);
    check("t2_dq_first", dq_r[3], 8'h42);
    check("t2_dq_data_last", dq_r[6], 8'h45);
    check("t2_dq_fill_first", dq_r[7], 8'hFF);
    check("t2_dq_fill_last", dq_r[10], 8'hFF);
    check("t2_dq_crc", dq_r[11], 8'hC5);
    check("t2_dm_fill", dm_r[8], 1'b0);

    // Second command during DATA: seamless continuation, queue drains.
    set_cfg(1'b0, 2'b00, 2'd1, 1'b0);
    clear_tbl(); wen_t[0] = 1'b1; wen_t[5] = 1'b1;
    run(22);
    check("t3_st10_data", st_r[10], S_DATA);
    check("t3_st11_data", st_r[11], S_DATA);
    check("t3_st18_data", st_r[18], S_DATA);
    check("t3_st19_post", st_r[19], S_POST);
    check("t3_st20_idle", st_r[20], S_IDLE);
    check("t3_st21_idle", st_r[21], S_IDLE);
    cnt = 0; for (int k = 0; k <= 22; k++) cnt += int'(qv_r[k]);
    check("t3_dq_valid_cycles", cnt, 16);
    cnt = 0; for (int k = 0; k <= 22; k++) cnt += int'(dv_r[k]);
    check("t3_dqs_valid_cycles", cnt, 19);
    check("t3_dq_seam", dq_r[12], 8'h4B);
    check("t3_dqs_seam", dqs_r[12], 2'b10);

    // Command during a 2-cycle postamble restarts with a full preamble.
    set_cfg(1'b0, 2'b00, 2'd1, 1'b1);
    clear_tbl(); wen_t[0] = 1'b1; wen_t[11] = 1'b1;
    run(27);
    check("t4_st11_post", st_r[11], S_POST);
    check("t4_st12_post", st_r[12], S_POST);
    check("t4_st13_pre", st_r[13], S_PRE);
    check("t4_st14_pre", st_r[14], S_PRE);
    check("t4_st15_data", st_r[15], S_DATA);
    check("t4_st22_data", st_r[22], S_DATA);
    check("t4_st24_post", st_r[24], S_POST);
    check("t4_st25_idle", st_r[25], S_IDLE);
    check("t4_dqs_pre_lo", dqs_r[14], 2'b00);
    check("t4_dqs_pre_last", dqs_r[15], 2'b10);
    check("t4_dv_pre", dv_r[14], 1'b1);
    check("t4_qv_pre", qv_r[14], 1'b0);
    check("t4_dq_data", dq_r[16], 8'h4F);

    // Overflow: two queued, third dropped, err_o sticks.
    set_cfg(1'b0, 2'b00, 2'd0, 1'b0);
    clear_tbl(); wen_t[0] = 1'b1; wen_t[3] = 1'b1; wen_t[4] = 1'b1; wen_t[5] = 1'b1;
    run(28);
    check("t5_err_before", er_r[5], 1'b0);
    check("t5_err_set", er_r[6], 1'b1);
    check("t5_st18_data", st_r[18], S_DATA);
    check("t5_st25_data", st_r[25], S_DATA);
    check("t5_st26_post", st_r[26], S_POST);
    check("t5_st27_idle", st_r[27], S_IDLE);
    check("t5_err_sticky", er_r[28], 1'b1);
    cnt = 0; for (int k = 0; k <= 28; k++) cnt += int'(qv_r[k]);
    check("t5_dq_valid_cycles", cnt, 24);

    // enable_i low for three cycles in DATA: full freeze, then resume.
    clear_tbl(); wen_t[0] = 1'b1; en_t[4] = 1'b0; en_t[5] = 1'b0; en_t[6] = 1'b0;
    run(16);
    check("t6_st6_data", st_r[6], S_DATA);
    check("t6_dq_hold_a", dq_r[5], 8'h43);
    check("t6_dq_hold_b", dq_r[7], 8'h43);
    check("t6_dq_resume", dq_r[8], 8'h47);
    check("t6_st12_data", st_r[12], S_DATA);
    check("t6_dq_last", dq_r[13], 8'h4C);
    check("t6_st13_post", st_r[13], S_POST);
    check("t6_st14_idle", st_r[14], S_IDLE);
    check("t6_err_still", er_r[14], 1'b1);

    // Reset pulse in the middle of a 4-cycle preamble.
    set_cfg(1'b0, 2'b00, 2'd3, 1'b0);
    clear_tbl(); wen_t[0] = 1'b1; rst_t[2] = 1'b1;
    run(5);
    check("t7_st1_pre", st_r[1], S_PRE);
    check("t7_st2_idle", st_r[2], S_IDLE);
    check("t7_dv_cleared", dv_r[2], 1'b0);
    check("t7_err_cleared", er_r[2], 1'b0);
    check("t7_st4_idle", st_r[4], S_IDLE);
    check("t7_dv_idle", dv_r[5], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
